// File: rtl/htgs4_reset_seq.sv
// Board reset sequencer: orders PLL lock, PERST# hold-off and link-up before releasing endpoint and core resets.
// Latency: input pin change reaches seq_state and reset outputs 3 clocks later (2 sync flops + state register).
// Backpressure: none; free-running control block with level inputs and registered level outputs.
module htgs4_reset_seq #(
    parameter int HOLD_CYCLES     = 200,
    parameter int LINK_TIMEOUT    = 33554432,
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int HB_LOG2         = 26
) (
    input  logic       sys0_clk,
    input  logic       sys0_rstn,
    input  logic       pcie_rstn,
    input  logic       pll_locked,
    input  logic       link_up,
    input  logic [7:0] usr_sw_i,
    output logic       pcie_core_rstn,
    output logic       core_rstn,
    output logic [2:0] seq_state,
    output logic [7:0] led
);

    typedef enum logic [2:0] {
        ST_RESET      = 3'd0,
        ST_WAIT_PLL   = 3'd1,
        ST_WAIT_PERST = 3'd2,
        ST_WAIT_LINK  = 3'd3,
        ST_RUN        = 3'd4,
        ST_FAULT      = 3'd5
    } state_t;

    localparam logic [31:0]        HOLD_LAST = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0]        LINK_LAST = 32'(LINK_TIMEOUT - 1);
    localparam logic [31:0]        DB_LAST   = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [HB_LOG2:0]   HB_ONE    = 1;

    // bit order: {sw, link, lock, perst}
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic             perst_s;
    logic             lock_s;
    logic             link_s;
    logic             sw_s;

    logic [31:0]      db_cnt;
    logic             sw_db;
    logic             sw_db_d;
    logic             sw_req;

    state_t           state;
    state_t           nxt_state;
    logic [31:0]      cnt;
    logic [31:0]      nxt_cnt;

    logic [HB_LOG2:0] hb_cnt;

    // Only the reset-request switch is wired; the rest of the DIP bank is ignored.
    logic             unused_sw;
    assign unused_sw = ^usr_sw_i[7:1];

    // Two-flop synchronizers for every asynchronous board input.
    always_ff @(posedge sys0_clk or negedge sys0_rstn) begin
        if (!sys0_rstn) begin
            sync1 <= 4'b0000;
            sync2 <= 4'b0000;
        end else begin
            sync1 <= {usr_sw_i[0], link_up, pll_locked, pcie_rstn};
            sync2 <= sync1;
        end
    end

    assign perst_s = sync2[0];
    assign lock_s  = sync2[1];
    assign link_s  = sync2[2];
    assign sw_s    = sync2[3];

    // Switch debounce: a new level must persist DEBOUNCE_CYCLES cycles before it is accepted.
    always_ff @(posedge sys0_clk or negedge sys0_rstn) begin
        if (!sys0_rstn) begin
            db_cnt  <= 32'd0;
            sw_db   <= 1'b0;
            sw_db_d <= 1'b0;
        end else begin
            sw_db_d <= sw_db;
            if (sw_s == sw_db) begin
                db_cnt <= 32'd0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt <= 32'd0;
                sw_db  <= sw_s;
            end else begin
                db_cnt <= db_cnt + 32'd1;
            end
        end
    end

    // One pulse per debounced press; holding the switch does not repeat it.
    assign sw_req = sw_db & ~sw_db_d;

    // Next-state and shared counter; lock loss outranks PERST#/switch, which outrank local moves.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = 32'd0;
        case (state)
            ST_RESET:      nxt_state = ST_WAIT_PLL;
            ST_WAIT_PLL:   if (lock_s) nxt_state = ST_WAIT_PERST;
            ST_WAIT_PERST: begin
                if (perst_s) begin
                    if (cnt == HOLD_LAST) nxt_state = ST_WAIT_LINK;
                    else                  nxt_cnt   = cnt + 32'd1;
                end
            end
            ST_WAIT_LINK: begin
                if (link_s)                 nxt_state = ST_RUN;
                else if (cnt == LINK_LAST)  nxt_state = ST_FAULT;
                else                        nxt_cnt   = cnt + 32'd1;
            end
            ST_RUN:        if (!link_s) nxt_state = ST_WAIT_LINK;
            ST_FAULT:      nxt_state = ST_FAULT;
            default:       nxt_state = ST_RESET;
        endcase

        if ((state == ST_WAIT_LINK || state == ST_RUN || state == ST_FAULT) &&
            (!perst_s || sw_req)) begin
            nxt_state = ST_WAIT_PERST;
        end

        if ((state == ST_WAIT_PERST || state == ST_WAIT_LINK ||
             state == ST_RUN || state == ST_FAULT) && !lock_s) begin
            nxt_state = ST_WAIT_PLL;
        end

        if (nxt_state != state) nxt_cnt = 32'd0;
    end

    // State register, shared counter, and reset outputs decoded from the next state.
    always_ff @(posedge sys0_clk or negedge sys0_rstn) begin
        if (!sys0_rstn) begin
            state          <= ST_RESET;
            cnt            <= 32'd0;
            pcie_core_rstn <= 1'b0;
            core_rstn      <= 1'b0;
        end else begin
            state          <= nxt_state;
            cnt            <= nxt_cnt;
            pcie_core_rstn <= (nxt_state == ST_WAIT_LINK) || (nxt_state == ST_RUN) ||
                              (nxt_state == ST_FAULT);
            core_rstn      <= (nxt_state == ST_RUN);
        end
    end

    // Free-running heartbeat counter for the alive LED.
    always_ff @(posedge sys0_clk or negedge sys0_rstn) begin
        if (!sys0_rstn) hb_cnt <= '0;
        else            hb_cnt <= hb_cnt + HB_ONE;
    end

    assign seq_state = state;
    assign led       = {(state == ST_FAULT), sw_db, hb_cnt[HB_LOG2], lock_s, link_s, state};

endmodule

// File: tb/tb_htgs4_reset_seq.sv
// Scoreboard bench for htgs4_reset_seq with short hold, timeout, debounce and heartbeat parameters.
// Expected snapshots are queued with a due cycle when inputs are driven and compared at that cycle.
// Inputs change 1 ns after a rising edge; outputs are sampled on the falling edge.
module tb_htgs4_reset_seq;

    localparam int HOLD = 8;
    localparam int TMO  = 16;
    localparam int DB   = 4;
    localparam int HBL  = 4;

    logic       sys0_clk = 1'b0;
    logic       sys0_rstn;
    logic       pcie_rstn;
    logic       pll_locked;
    logic       link_up;
    logic [7:0] usr_sw_i;
    logic       pcie_core_rstn;
    logic       core_rstn;
    logic [2:0] seq_state;
    logic [7:0] led;

    htgs4_reset_seq #(
        .HOLD_CYCLES(HOLD), .LINK_TIMEOUT(TMO), .DEBOUNCE_CYCLES(DB), .HB_LOG2(HBL)
    ) dut (
        .sys0_clk(sys0_clk), .sys0_rstn(sys0_rstn), .pcie_rstn(pcie_rstn),
        .pll_locked(pll_locked), .link_up(link_up), .usr_sw_i(usr_sw_i),
        .pcie_core_rstn(pcie_core_rstn), .core_rstn(core_rstn),
        .seq_state(seq_state), .led(led)
    );

    always #5 sys0_clk = ~sys0_clk;

    int cyc = 0;
    always @(posedge sys0_clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        int         due;
        logic [2:0] st;
        logic       pcie;
        logic       core;
        logic [4:0] led_lo;
        logic       flt;
        logic       sw;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   rel_cyc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Queue the expected outputs dly cycles after the current edge.
    task automatic expect_at(input string tag, input int dly, input logic [2:0] st,
                             input logic pcie, input logic core,
                             input logic link, input logic lock, input logic sw);
        exp_t e;
        e.tag    = tag;
        e.due    = cyc + dly;
        e.st     = st;
        e.pcie   = pcie;
        e.core   = core;
        e.led_lo = {lock, link, st};
        e.flt    = (st == 3'd5);
        e.sw     = sw;
        sb.push_back(e);
    endtask

    always @(negedge sys0_clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            check_eq({mon_e.tag, "_state"}, 32'(seq_state), 32'(mon_e.st));
            check_eq({mon_e.tag, "_pcie"},  32'(pcie_core_rstn), 32'(mon_e.pcie));
            check_eq({mon_e.tag, "_core"},  32'(core_rstn), 32'(mon_e.core));
            check_eq({mon_e.tag, "_led40"}, 32'(led[4:0]), 32'(mon_e.led_lo));
            check_eq({mon_e.tag, "_led7"},  32'(led[7]), 32'(mon_e.flt));
            check_eq({mon_e.tag, "_led6"},  32'(led[6]), 32'(mon_e.sw));
        end
    end

    task automatic step();
        @(posedge sys0_clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb.size() > 0; i++) @(negedge sys0_clk);
        check_eq("drain", 32'(sb.size()), 32'd0);
    endtask

    // Wait for the endpoint release and compare its delay against exp_dly with one clock of slack.
    task automatic wait_pcie_rise(input string tag, input int start, input int exp_dly);
        logic seen;
        int   d;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge sys0_clk);
            if (pcie_core_rstn) seen = 1'b1;
        end
        d = cyc - start;
        check_eq({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen)
            check_eq({tag, "_delay"}, (d >= exp_dly - 1 && d <= exp_dly + 1) ? exp_dly : d, exp_dly);
    endtask

    initial begin
        int d;
        sys0_rstn  = 1'b0;
        pcie_rstn  = 1'b1;
        pll_locked = 1'b1;
        link_up    = 1'b0;
        usr_sw_i   = 8'h00;

        repeat (3) @(posedge sys0_clk);
        @(negedge sys0_clk);
        check_eq("rst_pcie",  32'(pcie_core_rstn), 32'd0);
        check_eq("rst_core",  32'(core_rstn), 32'd0);
        check_eq("rst_state", 32'(seq_state), 32'd0);
        check_eq("rst_led",   32'(led), 32'd0);

        // Power-up with lock and PERST# already high.
        step();
        sys0_rstn = 1'b1;
        rel_cyc   = cyc;
        wait_pcie_rise("pwrup_release", rel_cyc, HOLD + 3);
        check_eq("pwrup_state", 32'(seq_state), 32'd3);

        step();
        link_up = 1'b1;
        expect_at("link_pre", 2, 3'd3, 1, 0, 1, 1, 0);
        expect_at("link_run", 3, 3'd4, 1, 1, 1, 1, 0);
        drain();

        // Link loss, then timeout into FAULT.
        step();
        link_up = 1'b0;
        expect_at("loss_pre",  2, 3'd4, 1, 1, 0, 1, 0);
        expect_at("loss_wl",   3, 3'd3, 1, 0, 0, 1, 0);
        expect_at("tmo_pre",  TMO + 2, 3'd3, 1, 0, 0, 1, 0);
        expect_at("tmo_fault", TMO + 3, 3'd5, 1, 0, 0, 1, 0);
        drain();

        d = cyc - rel_cyc;
        check_eq("heartbeat", 32'(led[5]), 32'((d >> HBL) & 1));

        step();
        pcie_rstn = 1'b0;
        expect_at("flt_perst_pre", 2, 3'd5, 1, 0, 0, 1, 0);
        expect_at("flt_perst",     3, 3'd2, 0, 0, 0, 1, 0);
        drain();

        // PERST# high, then a one-cycle low glitch part way through the hold.
        step();
        pcie_rstn = 1'b1;
        repeat (6) step();
        pcie_rstn = 1'b0;
        step();
        pcie_rstn = 1'b1;
        d = cyc;
        expect_at("glitch_hold", 6, 3'd2, 0, 0, 0, 1, 0);
        wait_pcie_rise("glitch_release", d, HOLD + 3);

        step();
        link_up = 1'b1;
        expect_at("glitch_run", 3, 3'd4, 1, 1, 1, 1, 0);
        drain();

        // Switch chatter shorter than the debounce window.
        step();
        usr_sw_i[0] = 1'b1;
        repeat (2) step();
        usr_sw_i[0] = 1'b0;
        step();
        usr_sw_i[0] = 1'b1;
        repeat (3) step();
        usr_sw_i[0] = 1'b0;
        expect_at("chatter", 8, 3'd4, 1, 1, 1, 1, 0);
        drain();

        // Stable press: one re-sequence, no retrigger while held.
        step();
        usr_sw_i[0] = 1'b1;
        expect_at("press_pre",  5, 3'd4, 1, 1, 1, 1, 0);
        expect_at("press_db",   6, 3'd4, 1, 1, 1, 1, 1);
        expect_at("press_perst", 7, 3'd2, 0, 0, 1, 1, 1);
        expect_at("press_wl",   HOLD + 7, 3'd3, 1, 0, 1, 1, 1);
        expect_at("press_run",  HOLD + 8, 3'd4, 1, 1, 1, 1, 1);
        expect_at("press_hold", 30, 3'd4, 1, 1, 1, 1, 1);
        drain();

        step();
        usr_sw_i[0] = 1'b0;
        expect_at("unpress_pre", 5, 3'd4, 1, 1, 1, 1, 1);
        expect_at("unpress_db",  6, 3'd4, 1, 1, 1, 1, 0);
        expect_at("unpress_run", 10, 3'd4, 1, 1, 1, 1, 0);
        drain();

        // Lock and PERST# drop together: lock wins.
        step();
        pll_locked = 1'b0;
        pcie_rstn  = 1'b0;
        expect_at("simul_pre", 2, 3'd4, 1, 1, 1, 0, 0);
        expect_at("simul_pll", 3, 3'd1, 0, 0, 1, 0, 0);
        drain();

        step();
        pll_locked = 1'b1;
        pcie_rstn  = 1'b1;
        expect_at("relock_pre",   2, 3'd1, 0, 0, 1, 1, 0);
        expect_at("relock_perst", 3, 3'd2, 0, 0, 1, 1, 0);
        expect_at("relock_wl",    HOLD + 3, 3'd3, 1, 0, 1, 1, 0);
        expect_at("relock_run",   HOLD + 4, 3'd4, 1, 1, 1, 1, 0);
        drain();

        // Asynchronous reset mid-operation, no clock edge in between.
        step();
        sys0_rstn = 1'b0;
        #1;
        check_eq("arst_pcie",  32'(pcie_core_rstn), 32'd0);
        check_eq("arst_core",  32'(core_rstn), 32'd0);
        check_eq("arst_state", 32'(seq_state), 32'd0);
        check_eq("arst_led",   32'(led), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
